// File: rtl/wli_encoder_if.sv
// Handshake bundle for wli_encoder: control word A..G in, recovered select and flags out.
// The encoder uses the slave modport; the upstream/downstream agent uses master.
interface wli_encoder_if;
  logic InValid;
  logic InReady;
  logic InA, InB, InC, InD, InE, InF, InG;
  logic OutValid;
  logic OutReady;
  logic SZero, SOne, STwo;
  logic OutIllegal;
  logic OutAmbig;

  modport master (
    output InValid, InA, InB, InC, InD, InE, InF, InG, OutReady,
    input  InReady, OutValid, SZero, SOne, STwo, OutIllegal, OutAmbig
  );

  modport slave (
    input  InValid, InA, InB, InC, InD, InE, InF, InG, OutReady,
    output InReady, OutValid, SZero, SOne, STwo, OutIllegal, OutAmbig
  );
endinterface

// File: rtl/wli_encoder.sv
// Recovers the 3-bit select from a 7-line write-line word; optional ErrCount under WLI_ERR_CNT_EN.
// Latency: a word accepted into an empty FIFO is on the outputs the next cycle.
// Backpressure: InReady = ~full from a registered count; a full FIFO refuses even on a same-cycle pop.

module syncFifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH-1:0] pushData,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] count;
  logic [WIDTH-1:0] lastPop;
  logic             doPush, doPop;

  assign pushReady = (count != OCC_W'(DEPTH));
  assign popValid  = (count != '0);
  assign doPush    = pushValid & pushReady;
  assign doPop     = popReady & popValid;
  // While empty the head shows the last entry popped (zero after reset).
  assign popData   = popValid ? mem[rdPtr] : lastPop;

  always_ff @(posedge Clock) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      lastPop <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr   <= rdPtr + PTR_W'(1);
        lastPop <= mem[rdPtr];
      end
      if (doPush && !doPop) begin
        count <= count + OCC_W'(1);
      end else if (doPop && !doPush) begin
        count <= count - OCC_W'(1);
      end
    end
  end
endmodule

module wli_encoder #(
  parameter int DEPTH        = 4,
  parameter bit DROP_ILLEGAL = 1'b0
`ifdef WLI_ERR_CNT_EN
  ,
  parameter int CNT_W        = 8
`endif
) (
  input  logic             Clock,
  input  logic             Reset,
  wli_encoder_if.slave     bus
`ifdef WLI_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ErrCount
`endif
);
  typedef struct packed {
    logic [2:0] sel;
    logic       illegal;
    logic       ambig;
  } wliEntry;

  wliEntry    encWord;
  wliEntry    headWord;
  logic [6:0] word;
  logic       pushValid;

  assign word = {bus.InA, bus.InB, bus.InC, bus.InD, bus.InE, bus.InF, bus.InG};

  // Where several selects drive the same word, the lowest select is reported.
  always_comb begin
    encWord = '0;
    case (word)
      7'b1000111: begin
        encWord.sel   = 3'b000;
        encWord.ambig = 1'b1;
      end
      7'b0000110: encWord.sel = 3'b001;
      7'b0000111: begin
        encWord.sel   = 3'b010;
        encWord.ambig = 1'b1;
      end
      7'b1111111: encWord.sel = 3'b100;
      7'b0111111: encWord.sel = 3'b101;
      default:    encWord.illegal = 1'b1;
    endcase
  end

  // A dropped illegal word still completes the handshake; it just never reaches the FIFO.
  assign pushValid = bus.InValid & ~(DROP_ILLEGAL & encWord.illegal);

  syncFifo #(
    .WIDTH($bits(wliEntry)),
    .DEPTH(DEPTH)
  ) fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .pushValid(pushValid),
    .pushReady(bus.InReady),
    .pushData (encWord),
    .popValid (bus.OutValid),
    .popReady (bus.OutReady),
    .popData  (headWord)
  );

  assign {bus.STwo, bus.SOne, bus.SZero} = headWord.sel;
  assign bus.OutIllegal = headWord.illegal;
  assign bus.OutAmbig   = headWord.ambig;

`ifdef WLI_ERR_CNT_EN
  logic accept;
  assign accept = bus.InValid & bus.InReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ErrCount <= '0;
    end else if (accept && encWord.illegal && (ErrCount != '1)) begin
      ErrCount <= ErrCount + CNT_W'(1);
    end
  end
`endif
endmodule
